// File: rtl/i2s_tx.sv
// ---------------------------------------------------------------------------
// i2s_tx : stereo Philips-I2S output serializer.
//
// Takes signed stereo sample pairs over a valid/ready handshake into a single
// holding register and transmits one pair per frame as bit clock, word select
// and MSB-first serial data. All I2S timing comes from sys_clk: each BCLK
// period is BCLK_DIV sys_clk cycles and each channel slot is SLOT_W BCLK
// periods, so a frame is 2*SLOT_W*BCLK_DIV cycles.
//
// Ports:
//   sys_clk          system clock
//   sys_rst          asynchronous active-low reset
//   s_valid/s_ready  sample-pair handshake (s_ready = holding register empty)
//   s_left/s_right   left/right samples, two's complement, DATA_W bits
//   i2s_bclk         bit clock (low BCLK_DIV/2 cycles, then high)
//   i2s_lrck         word select, 0 = left slot, 1 = right slot
//   i2s_sdata        serial data, one-BCLK delay after LRCK edge, MSB first
//   frame_start      one-cycle pulse when a new frame is loaded
//   underrun         one-cycle pulse when a frame is loaded with no pending pair
//   underrun_sticky  set on underrun, cleared only by reset
//
// Build option:
//   I2S_TX_HOLD_EN   defined: an underrun repeats the previous pair;
//                    undefined: an underrun transmits silence (zeros).
// ---------------------------------------------------------------------------
module i2s_tx #(
    parameter int unsigned DATA_W   = 24,
    parameter int unsigned SLOT_W   = 25,
    parameter int unsigned BCLK_DIV = 25
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_left,
    input  logic [DATA_W-1:0] s_right,
    output logic              i2s_bclk,
    output logic              i2s_lrck,
    output logic              i2s_sdata,
    output logic              frame_start,
    output logic              underrun,
    output logic              underrun_sticky
);

    localparam int unsigned CNT_W = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
    localparam int unsigned IDX_W = $clog2(2 * SLOT_W);

    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(BCLK_DIV - 1);
    localparam logic [CNT_W-1:0] LOW_CYC   = CNT_W'(BCLK_DIV / 2);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(2 * SLOT_W - 1);
    localparam logic [IDX_W-1:0] SLOT_LEN  = IDX_W'(SLOT_W);
    localparam logic [IDX_W-1:0] DATA_LAST = IDX_W'(DATA_W);

    // State registers
    logic [CNT_W-1:0]  r_bclk_cnt;
    logic [IDX_W-1:0]  r_bit_idx;
    logic              r_bclk;
    logic              r_lrck;
    logic              r_sdata;
    logic              r_frame_start;
    logic              r_underrun;
    logic              r_sticky;
    logic              r_hold_full;
    logic [DATA_W-1:0] r_hold_l;
    logic [DATA_W-1:0] r_hold_r;
    logic [DATA_W-1:0] r_act_l;
    logic [DATA_W-1:0] r_act_r;

    // Combinational helpers
    logic              w_tick;
    logic              w_fb;
    logic              w_accept;
    logic [CNT_W-1:0]  w_cnt_next;
    logic [IDX_W-1:0]  w_idx_next;
    logic              w_right;
    logic [IDX_W-1:0]  w_pos;
    logic [IDX_W-1:0]  w_sh_amt;
    logic [DATA_W-1:0] w_chan;
    logic [DATA_W-1:0] w_shifted;
    logic              w_bit;

    assign w_tick     = (r_bclk_cnt == CNT_LAST);
    assign w_fb       = w_tick && (r_bit_idx == IDX_LAST);
    assign w_accept   = s_valid && !r_hold_full;
    assign w_cnt_next = w_tick ? '0 : r_bclk_cnt + 1'b1;

    // Serial outputs are computed for the bit position being entered on tick,
    // so they change together with the BCLK falling edge.
    assign w_idx_next = (r_bit_idx == IDX_LAST) ? '0 : r_bit_idx + 1'b1;
    assign w_right    = (w_idx_next >= SLOT_LEN);
    assign w_pos      = w_right ? (w_idx_next - SLOT_LEN) : w_idx_next;
    assign w_chan     = w_right ? r_act_r : r_act_l;

    // Position p (1..DATA_W) carries channel bit DATA_W-p: shift it up to the MSB.
    assign w_sh_amt   = w_pos - 1'b1;
    assign w_shifted  = w_chan << w_sh_amt;
    assign w_bit      = (w_pos != '0) && (w_pos <= DATA_LAST) && w_shifted[DATA_W-1];

    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            r_bclk_cnt    <= '0;
            r_bit_idx     <= '0;
            r_bclk        <= 1'b0;
            r_lrck        <= 1'b0;
            r_sdata       <= 1'b0;
            r_frame_start <= 1'b0;
            r_underrun    <= 1'b0;
            r_sticky      <= 1'b0;
            r_hold_full   <= 1'b0;
            r_hold_l      <= '0;
            r_hold_r      <= '0;
            r_act_l       <= '0;
            r_act_r       <= '0;
        end else begin
            r_bclk_cnt    <= w_cnt_next;
            // Low for counts 0..LOW_CYC-1, so the falling edge lands on tick.
            r_bclk        <= (w_cnt_next >= LOW_CYC);
            r_frame_start <= w_fb;
            r_underrun    <= w_fb && !r_hold_full;
            if (w_fb && !r_hold_full) begin
                r_sticky <= 1'b1;
            end

            if (w_tick) begin
                r_bit_idx <= w_idx_next;
                r_lrck    <= w_right;
                r_sdata   <= w_bit;
            end

            // Accept only happens when empty, so it never collides with a
            // consume; a same-cycle accept is kept for the next frame.
            if (w_accept) begin
                r_hold_full <= 1'b1;
                r_hold_l    <= s_left;
                r_hold_r    <= s_right;
            end else if (w_fb) begin
                r_hold_full <= 1'b0;
            end

            if (w_fb) begin
                if (r_hold_full) begin
                    r_act_l <= r_hold_l;
                    r_act_r <= r_hold_r;
                end else begin
`ifdef I2S_TX_HOLD_EN
                    // Repeat the previous pair: active registers keep their value.
                    r_act_l <= r_act_l;
                    r_act_r <= r_act_r;
`else
                    r_act_l <= '0;
                    r_act_r <= '0;
`endif
                end
            end
        end
    end

    assign s_ready         = !r_hold_full;
    assign i2s_bclk        = r_bclk;
    assign i2s_lrck        = r_lrck;
    assign i2s_sdata       = r_sdata;
    assign frame_start     = r_frame_start;
    assign underrun        = r_underrun;
    assign underrun_sticky = r_sticky;

endmodule

// File: tb/tb_i2s_tx.sv
`timescale 1ns/1ps
module tb_i2s_tx;

    localparam int DW     = 24;
    localparam int SW     = 25;
    localparam int DIV    = 25;
    localparam int FRAME  = 2 * SW * DIV;
    localparam int SW2    = 32;
    localparam int DIV2   = 4;
    localparam int FRAME2 = 2 * SW2 * DIV2;

    logic          sys_clk = 1'b0;
    logic          sys_rst = 1'b0;

    logic          s_valid = 1'b0;
    logic          s_ready;
    logic [DW-1:0] s_left  = '0;
    logic [DW-1:0] s_right = '0;
    logic          i2s_bclk, i2s_lrck, i2s_sdata;
    logic          frame_start, underrun, underrun_sticky;

    logic          s2_valid = 1'b0;
    logic          s2_ready;
    logic [DW-1:0] s2_left  = '0;
    logic [DW-1:0] s2_right = '0;
    logic          s2_bclk, s2_lrck, s2_sdata;
    logic          s2_frame_start, s2_underrun, s2_sticky;

    int vectors = 0;
    int errors  = 0;
    int cyc     = 0;
    int g_fe    = 0;

    // Pair currently held by the transmitter, per the behavioural model.
    logic [DW-1:0] last_l = '0;
    logic [DW-1:0] last_r = '0;

    typedef struct packed {
        logic [DW-1:0] l;
        logic [DW-1:0] r;
        int            acc;
    } pair_t;

    i2s_tx u_dut (
        .sys_clk         (sys_clk),
        .sys_rst         (sys_rst),
        .s_valid         (s_valid),
        .s_ready         (s_ready),
        .s_left          (s_left),
        .s_right         (s_right),
        .i2s_bclk        (i2s_bclk),
        .i2s_lrck        (i2s_lrck),
        .i2s_sdata       (i2s_sdata),
        .frame_start     (frame_start),
        .underrun        (underrun),
        .underrun_sticky (underrun_sticky)
    );

    i2s_tx #(
        .DATA_W   (DW),
        .SLOT_W   (SW2),
        .BCLK_DIV (DIV2)
    ) u_dut_small (
        .sys_clk         (sys_clk),
        .sys_rst         (sys_rst),
        .s_valid         (s2_valid),
        .s_ready         (s2_ready),
        .s_left          (s2_left),
        .s_right         (s2_right),
        .i2s_bclk        (s2_bclk),
        .i2s_lrck        (s2_lrck),
        .i2s_sdata       (s2_sdata),
        .frame_start     (s2_frame_start),
        .underrun        (s2_underrun),
        .underrun_sticky (s2_sticky)
    );

    always #5 sys_clk = ~sys_clk;
    always @(posedge sys_clk) cyc++;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Expected serial frame, indexed by bit position within the frame.
    function automatic logic [63:0] exp_frame(input logic [DW-1:0] l, input logic [DW-1:0] r,
                                              input int slot);
        logic [63:0]   f;
        logic [DW-1:0] ch;
        int            p;
        f = '0;
        for (int i = 0; i < 2 * slot; i++) begin
            p  = i % slot;
            ch = (i < slot) ? l : r;
            if (p >= 1 && p <= DW) f[i] = ch[DW-p];
        end
        return f;
    endfunction

    function automatic logic [DW-1:0] rnd();
        return DW'($urandom);
    endfunction

    // Records one frame of the default instance as seen on BCLK rising edges.
    task automatic capture_frame(input bit at_start, output logic [63:0] bits, output int fedge,
                                 output logic und, output int lr_bad, output logic rdy_fs);
        int   n;
        logic prev;
        bits   = '1;
        lr_bad = 0;
        fedge  = -1;
        und    = 1'bx;
        rdy_fs = 1'bx;
        n      = 0;
        if (!at_start) begin
            do begin
                @(negedge sys_clk);
                n++;
            end while (frame_start !== 1'b1 && n < 2 * FRAME);
        end
        if (frame_start === 1'b1) begin
            fedge  = cyc;
            g_fe   = cyc;
            und    = underrun;
            rdy_fs = s_ready;
            bits   = '0;
            for (int i = 0; i < 2 * SW; i++) begin
                n = 0;
                do begin
                    prev = i2s_bclk;
                    @(negedge sys_clk);
                    n++;
                end while (!(prev === 1'b0 && i2s_bclk === 1'b1) && n < 4 * DIV);
                bits[i] = (n < 4 * DIV) ? i2s_sdata : 1'bx;
                if (i2s_lrck !== (i >= SW)) lr_bad++;
            end
        end
    endtask

    task automatic test_reset();
        int n, bad_clk, bad_lr, bad_sd, early;
        sys_rst = 1'b0;
        repeat (3) @(negedge sys_clk);
        vectors++;
        if ({i2s_bclk, i2s_lrck, i2s_sdata, frame_start, underrun, underrun_sticky, s_ready}
            !== 7'b0000001) begin
            errors++;
            $display("FAIL reset_outputs: got %b want 0000001",
                     {i2s_bclk, i2s_lrck, i2s_sdata, frame_start, underrun, underrun_sticky,
                      s_ready});
        end
        sys_rst = 1'b1;
        n = 0; bad_clk = 0; bad_lr = 0; bad_sd = 0; early = 0;
        do begin
            @(negedge sys_clk);
            n++;
            if (i2s_bclk !== ((n % DIV) >= DIV / 2)) bad_clk++;
            if (i2s_lrck !== (((n / DIV) % (2 * SW)) >= SW)) bad_lr++;
            if (i2s_sdata !== 1'b0) bad_sd++;
            if (frame_start !== 1'b1 && (underrun !== 1'b0 || underrun_sticky !== 1'b0)) early++;
        end while (frame_start !== 1'b1 && n < 2 * FRAME);
        g_fe = cyc;
        vectors++;
        if (n != FRAME) begin
            errors++; $display("FAIL first_fb_cycle: got %0d want %0d", n, FRAME);
        end
        vectors++;
        if (bad_clk != 0) begin
            errors++; $display("FAIL bclk_shape: %0d bad cycles, want 0", bad_clk);
        end
        vectors++;
        if (bad_lr != 0) begin
            errors++; $display("FAIL lrck_shape: %0d bad cycles, want 0", bad_lr);
        end
        vectors++;
        if (bad_sd != 0 || early != 0) begin
            errors++; $display("FAIL idle_frame: sdata bad %0d, early flags %0d, want 0/0",
                               bad_sd, early);
        end
        vectors++;
        if (underrun !== 1'b1) begin
            errors++; $display("FAIL first_underrun: got %b want 1", underrun);
        end
        @(negedge sys_clk);
        vectors++;
        if ({frame_start, underrun, underrun_sticky} !== 3'b001) begin
            errors++; $display("FAIL pulse_sticky: got %b want 001",
                               {frame_start, underrun, underrun_sticky});
        end
        last_l = '0;
        last_r = '0;
    endtask

    task automatic test_pattern();
        logic [63:0] got, exp;
        int          fe, lrb;
        logic        und, rdy, rdy_fs;
        s_left  = 24'h800001;
        s_right = 24'h7FFFFE;
        s_valid = 1'b1;
        rdy     = s_ready;
        @(negedge sys_clk);
        s_valid = 1'b0;
        vectors++;
        if (!(rdy === 1'b1 && s_ready === 1'b0)) begin
            errors++; $display("FAIL pattern_accept: ready before/after %b%b want 10", rdy, s_ready);
        end
        capture_frame(1'b0, got, fe, und, lrb, rdy_fs);
        exp = exp_frame(24'h800001, 24'h7FFFFE, SW);
        vectors++;
        if (got !== exp) begin
            errors++; $display("FAIL pattern_bits: got %h want %h", got, exp);
        end
        vectors++;
        if (und !== 1'b0 || lrb != 0 || rdy_fs !== 1'b1) begin
            errors++; $display("FAIL pattern_flags: und %b lrck_bad %0d ready %b want 0 0 1",
                               und, lrb, rdy_fs);
        end
        last_l = 24'h800001;
        last_r = 24'h7FFFFE;
    endtask

    task automatic test_back_to_back();
        pair_t q[$];
        int    acc_edges[4];
        fork
            begin : producer
                logic rdy;
                int   n;
                pair_t p;
                for (int k = 0; k < 4; k++) begin
                    s_left  = rnd();
                    s_right = rnd();
                    s_valid = 1'b1;
                    n = 0;
                    do begin
                        rdy = s_ready;
                        @(negedge sys_clk);
                        n++;
                    end while (rdy !== 1'b1 && n < 2 * FRAME);
                    p.l = s_left; p.r = s_right; p.acc = cyc;
                    acc_edges[k] = cyc;
                    q.push_back(p);
                end
                s_valid = 1'b0;
            end
            begin : consumer
                logic [63:0]   got, exp;
                logic [DW-1:0] el, er;
                int            fe, lrb;
                logic          und, eu, rdy_fs;
                for (int f = 0; f < 5; f++) begin
                    capture_frame(1'b0, got, fe, und, lrb, rdy_fs);
                    if (q.size() > 0 && q[0].acc < fe) begin
                        el = q[0].l; er = q[0].r; eu = 1'b0;
                        void'(q.pop_front());
                    end else begin
`ifdef I2S_TX_HOLD_EN
                        el = last_l; er = last_r;
`else
                        el = '0; er = '0;
`endif
                        eu = 1'b1;
                    end
                    last_l = el; last_r = er;
                    exp = exp_frame(el, er, SW);
                    vectors++;
                    if (got !== exp || und !== eu || lrb != 0) begin
                        errors++;
                        $display("FAIL stream_frame%0d: bits %h und %b lrbad %0d want %h %b 0",
                                 f, got, und, lrb, exp, eu);
                    end
                end
            end
        join
        for (int k = 2; k < 4; k++) begin
            vectors++;
            if (acc_edges[k] - acc_edges[k-1] != FRAME) begin
                errors++; $display("FAIL stream_accept_spacing%0d: got %0d want %0d",
                                   k, acc_edges[k] - acc_edges[k-1], FRAME);
            end
        end
    endtask

    task automatic test_underrun_same_cycle();
        logic [63:0]   got, exp;
        logic [DW-1:0] pl, pr;
        int            fe, lrb, n, target;
        logic          und, rdy, rdy_fs;
        target = g_fe + FRAME - 1;
        n = 0;
        while (cyc < target && n < 2 * FRAME) begin
            @(negedge sys_clk);
            n++;
        end
        pl = rnd(); pr = rnd();
        s_left = pl; s_right = pr; s_valid = 1'b1;
        rdy = s_ready;
        @(negedge sys_clk);
        s_valid = 1'b0;
        vectors++;
        if ({rdy, s_ready, frame_start, underrun} !== 4'b1011) begin
            errors++; $display("FAIL same_cycle_fb: rdy/ready/fs/und %b want 1011",
                               {rdy, s_ready, frame_start, underrun});
        end
        capture_frame(1'b1, got, fe, und, lrb, rdy_fs);
`ifdef I2S_TX_HOLD_EN
        exp = exp_frame(last_l, last_r, SW);
`else
        exp = exp_frame('0, '0, SW);
`endif
        vectors++;
        if (got !== exp || und !== 1'b1) begin
            errors++; $display("FAIL underrun_frame: bits %h und %b want %h 1", got, und, exp);
        end
        capture_frame(1'b0, got, fe, und, lrb, rdy_fs);
        exp = exp_frame(pl, pr, SW);
        vectors++;
        if (got !== exp || und !== 1'b0) begin
            errors++; $display("FAIL deferred_pair: bits %h und %b want %h 0", got, und, exp);
        end
        last_l = pl; last_r = pr;
    endtask

    task automatic test_reset_mid_frame();
        int   n, bad_lr, bad_sd;
        logic rdy;
        n = 0;
        do begin
            @(negedge sys_clk);
            n++;
        end while (frame_start !== 1'b1 && n < 2 * FRAME);
        s_left = rnd() | 24'h400000; s_right = rnd() | 24'h400000; s_valid = 1'b1;
        rdy = s_ready;
        @(negedge sys_clk);
        s_valid = 1'b0;
        repeat (800) @(negedge sys_clk);
        vectors++;
        if ({rdy, s_ready, i2s_lrck} !== 3'b101) begin
            errors++; $display("FAIL mid_setup: rdy/ready/lrck %b want 101", {rdy, s_ready, i2s_lrck});
        end
        #2 sys_rst = 1'b0;
        #1;
        vectors++;
        if ({i2s_bclk, i2s_lrck, i2s_sdata, frame_start, underrun, underrun_sticky, s_ready}
            !== 7'b0000001) begin
            errors++;
            $display("FAIL async_reset: got %b want 0000001",
                     {i2s_bclk, i2s_lrck, i2s_sdata, frame_start, underrun, underrun_sticky,
                      s_ready});
        end
        @(negedge sys_clk);
        @(negedge sys_clk);
        sys_rst = 1'b1;
        n = 0; bad_lr = 0; bad_sd = 0;
        do begin
            @(negedge sys_clk);
            n++;
            if (i2s_lrck !== (((n / DIV) % (2 * SW)) >= SW)) bad_lr++;
            if (i2s_sdata !== 1'b0 || s_ready !== 1'b1) bad_sd++;
        end while (frame_start !== 1'b1 && n < 2 * FRAME);
        vectors++;
        if (n != FRAME || underrun !== 1'b1 || bad_lr != 0) begin
            errors++; $display("FAIL restart_timing: fb at %0d und %b lrbad %0d want %0d 1 0",
                               n, underrun, bad_lr, FRAME);
        end
        repeat (FRAME) begin
            @(negedge sys_clk);
            if (i2s_sdata !== 1'b0) bad_sd++;
        end
        vectors++;
        if (bad_sd != 0) begin
            errors++; $display("FAIL pending_discarded: %0d bad cycles want 0", bad_sd);
        end
        last_l = '0; last_r = '0;
    endtask

    task automatic test_small_cfg();
        logic [63:0]   bits, exp;
        logic [DW-1:0] pl, pr;
        logic          rdy, prev, und;
        int            n, bi, bad_clk, bad_lr, early;
        pl = rnd(); pr = rnd();
        s2_left = pl; s2_right = pr; s2_valid = 1'b1;
        rdy = s2_ready;
        @(negedge sys_clk);
        s2_valid = 1'b0;
        n = 0;
        do begin
            @(negedge sys_clk);
            n++;
        end while (s2_frame_start !== 1'b1 && n < 2 * FRAME2);
        und = s2_underrun;
        bits = '0; bi = 0; bad_clk = 0; bad_lr = 0; early = 0;
        prev = s2_bclk;
        for (int k = 1; k <= FRAME2; k++) begin
            @(negedge sys_clk);
            if (s2_bclk !== ((k % DIV2) >= DIV2 / 2)) bad_clk++;
            if (prev === 1'b0 && s2_bclk === 1'b1 && bi < 64) begin
                bits[bi] = s2_sdata;
                if (s2_lrck !== (bi >= SW2)) bad_lr++;
                bi++;
            end
            prev = s2_bclk;
            if (k < FRAME2 && s2_frame_start !== 1'b0) early++;
        end
        vectors++;
        if (rdy !== 1'b1 || und !== 1'b0 || s2_frame_start !== 1'b1 || early != 0) begin
            errors++; $display("FAIL small_frame_timing: rdy %b und %b fs256 %b early %0d want 1 0 1 0",
                               rdy, und, s2_frame_start, early);
        end
        vectors++;
        if (bad_clk != 0 || bad_lr != 0 || bi != 2 * SW2) begin
            errors++; $display("FAIL small_clocks: bclkbad %0d lrbad %0d bits %0d want 0 0 %0d",
                               bad_clk, bad_lr, bi, 2 * SW2);
        end
        exp = exp_frame(pl, pr, SW2);
        vectors++;
        if (bits !== exp) begin
            errors++; $display("FAIL small_bits: got %h want %h", bits, exp);
        end
    endtask

    initial begin
        test_reset();
        test_pattern();
        test_back_to_back();
        test_underrun_same_cycle();
        test_reset_mid_frame();
        test_small_cfg();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
